// File: rtl/nrzi_frame_rx.sv
// Receive side of the toggle-encoded serial link.
// A line transition decodes as '1' and a held line decodes as '0'. The block
// hunts for the sync byte, removes stuffed '1's, assembles bytes LSB first,
// and ends the frame when it sees a run of zeros longer than the stuffing
// rule allows.
//
// state | meaning
// ------+-------------------------------------------------------------
// HUNT  | slide decoded bits through the shift register until sync
// DATA  | in frame: destuff, assemble bytes, watch for end-of-frame
module nrzi_frame_rx #(
  parameter logic [7:0] SYNC_PATTERN = 8'h7E,
  parameter int         MAX_ZEROS    = 6,
  parameter int         MAX_LEN      = 255
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       LineIn,
  input  logic       BitEn,
  output logic [7:0] DataOut,
  output logic       DataValid,
  output logic       FrameStart,
  output logic       FrameDone,
  output logic       FrameErr,
  output logic       Busy,
  output logic [7:0] FrameLen
);

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam logic [2:0] ZMAX    = 3'(MAX_ZEROS);
  localparam logic [3:0] BC_ZMAX = {1'b0, ZMAX};
  localparam logic [7:0] LMAX    = 8'(MAX_LEN);

  state_t      state;
  logic        prev_line;
  logic [7:0]  shreg;
  logic [3:0]  bit_cnt;
  logic [2:0]  zero_run;

  logic        d;
  logic [7:0]  sh_next;
  logic [3:0]  bc_next;

  // Decoded bit and the candidate next values of the assembly registers.
  assign d       = LineIn ^ prev_line;
  assign sh_next = {d, shreg[7:1]};
  assign bc_next = bit_cnt + 4'd1;

  // Busy follows the state register directly, so it is still a registered output.
  assign Busy = (state == DATA);

  // Decoder, sync hunt, destuffing, byte assembly and frame termination.
  always_ff @(posedge Clock) begin
    DataValid  <= 1'b0;
    FrameStart <= 1'b0;
    FrameDone  <= 1'b0;
    FrameErr   <= 1'b0;
    if (!Reset) begin
      state     <= HUNT;
      prev_line <= 1'b1;
      shreg     <= 8'h00;
      bit_cnt   <= 4'd0;
      zero_run  <= 3'd0;
      DataOut   <= 8'h00;
      FrameLen  <= 8'h00;
    end else if (BitEn) begin
      prev_line <= LineIn;
      case (state)
        HUNT: begin
          shreg <= sh_next;
          if (sh_next == SYNC_PATTERN) begin
            FrameStart <= 1'b1;
            state      <= DATA;
            bit_cnt    <= 4'd0;
            zero_run   <= 3'd0;
            FrameLen   <= 8'h00;
          end
        end
        DATA: begin
          if (zero_run == ZMAX) begin
            if (d) begin
              // Stuffed '1': dropped, does not count as a data bit.
              zero_run <= 3'd0;
            end else begin
              // End-of-frame marker. A clean end leaves only marker zeros
              // in the partial byte; anything more means a truncated byte.
              state    <= HUNT;
              shreg    <= 8'h00;
              bit_cnt  <= 4'd0;
              zero_run <= 3'd0;
              if (bit_cnt <= BC_ZMAX) FrameDone <= 1'b1;
              else                    FrameErr  <= 1'b1;
            end
          end else begin
            shreg    <= sh_next;
            zero_run <= d ? 3'd0 : zero_run + 3'd1;
            if (bc_next == 4'd8) begin
              bit_cnt <= 4'd0;
              if (FrameLen < LMAX) begin
                DataOut   <= sh_next;
                DataValid <= 1'b1;
                FrameLen  <= FrameLen + 8'd1;
              end else begin
                // Overlong frame: abandon it, keeping the last good byte visible.
                FrameErr <= 1'b1;
                state    <= HUNT;
                shreg    <= 8'h00;
                zero_run <= 3'd0;
              end
            end else begin
              bit_cnt <= bc_next;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_nrzi_frame_rx.sv
// Self-checking bench for nrzi_frame_rx: a table-driven main frame plus
// hand-written sequences for stuffing, bad end of frame, length overflow and
// reset mid-frame. Expected outputs are queued when a bit is driven and
// popped for comparison after the sampling edge.
module tb_nrzi_frame_rx;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       LineIn = 1'b1;
  logic       BitEn = 1'b0;

  logic [7:0] DataOut1, FrameLen1, DataOut2, FrameLen2;
  logic       DataValid1, FrameStart1, FrameDone1, FrameErr1, Busy1;
  logic       DataValid2, FrameStart2, FrameDone2, FrameErr2, Busy2;

  // Main instance with default parameters.
  nrzi_frame_rx dut (
    .Clock(Clock), .Reset(Reset), .LineIn(LineIn), .BitEn(BitEn),
    .DataOut(DataOut1), .DataValid(DataValid1), .FrameStart(FrameStart1),
    .FrameDone(FrameDone1), .FrameErr(FrameErr1), .Busy(Busy1), .FrameLen(FrameLen1)
  );

  // Short-frame instance used for the length overflow case.
  nrzi_frame_rx #(.MAX_LEN(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .LineIn(LineIn), .BitEn(BitEn),
    .DataOut(DataOut2), .DataValid(DataValid2), .FrameStart(FrameStart2),
    .FrameDone(FrameDone2), .FrameErr(FrameErr2), .Busy(Busy2), .FrameLen(FrameLen2)
  );

  always #5 Clock = ~Clock;

  // Pulse bit order: {DataValid, FrameStart, FrameDone, FrameErr}
  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_DV   = 4'b1000;
  localparam logic [3:0] P_FS   = 4'b0100;
  localparam logic [3:0] P_FD   = 4'b0010;
  localparam logic [3:0] P_FE   = 4'b0001;

  typedef struct {
    logic [3:0] p;
    logic       busy;
    logic [7:0] data;
    logic [7:0] len;
  } exp_t;

  typedef struct {
    logic line;
    int   gap;
    exp_t e;
  } vec_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic sel2 = 1'b0;
  logic line_lvl = 1'b1;
  logic [7:0] e_data = 8'h00;
  logic [7:0] e_len  = 8'h00;

  logic [3:0] o_p;
  logic       o_busy;
  logic [7:0] o_data, o_len;
  assign o_p    = sel2 ? {DataValid2, FrameStart2, FrameDone2, FrameErr2}
                       : {DataValid1, FrameStart1, FrameDone1, FrameErr1};
  assign o_busy = sel2 ? Busy2 : Busy1;
  assign o_data = sel2 ? DataOut2 : DataOut1;
  assign o_len  = sel2 ? FrameLen2 : FrameLen1;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got pulses %b expected an entry", tag, o_p);
      return;
    end
    e = q.pop_front();
    cmp({tag, ".pulses"}, {4'h0, o_p}, {4'h0, e.p});
    cmp({tag, ".busy"}, {7'h0, o_busy}, {7'h0, e.busy});
    cmp({tag, ".data"}, o_data, e.data);
    cmp({tag, ".len"}, o_len, e.len);
  endtask

  // One line sample, followed by 'gap' idle cycles in which no pulse may appear.
  task automatic drive(input logic line, input int gap, input exp_t e, input string tag);
    @(negedge Clock);
    LineIn = line;
    BitEn  = 1'b1;
    q.push_back(e);
    @(posedge Clock);
    #1;
    check_pop(tag);
    for (int g = 0; g < gap; g++) begin
      @(negedge Clock);
      BitEn = 1'b0;
      @(posedge Clock);
      #1;
      cmp({tag, ".idle_pulses"}, {4'h0, o_p}, 8'h00);
    end
  endtask

  // Send one decoded bit; the expectation describes the outputs after it.
  task automatic send_dec(input logic d, input logic [3:0] p, input logic busy,
                          input string tag);
    exp_t e;
    line_lvl = line_lvl ^ d;
    e.p = p; e.busy = busy; e.data = e_data; e.len = e_len;
    drive(line_lvl, int'($urandom_range(0, 2)), e, tag);
  endtask

  // Send n decoded bits of b, LSB first; only the last bit carries 'p_last'.
  task automatic send_byte(input logic [7:0] b, input int n, input logic [3:0] p_last,
                           input logic busy_mid, input logic busy_last,
                           input logic [7:0] data_last, input logic [7:0] len_last,
                           input string tag);
    logic [7:0] bb;
    bb = b;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        e_data = data_last;
        e_len  = len_last;
        send_dec(bb[i], p_last, busy_last, tag);
      end else begin
        send_dec(bb[i], P_NONE, busy_mid, tag);
      end
    end
  endtask

  task automatic send_zeros(input int n, input logic [3:0] p_last, input logic busy_last,
                            input string tag);
    for (int i = 0; i < n; i++)
      send_dec(1'b0, (i == n - 1) ? p_last : P_NONE, (i == n - 1) ? busy_last : 1'b1, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, ".DataOut"}, DataOut1, 8'h00);
    cmp({tag, ".FrameLen"}, FrameLen1, 8'h00);
    cmp({tag, ".pulses_busy"},
        {3'b000, DataValid1, FrameStart1, FrameDone1, FrameErr1, Busy1}, 8'h00);
    cmp({tag, ".dut2"}, {DataOut2 | FrameLen2}, 8'h00);
  endtask

  task automatic do_reset(input int cycles, input string tag);
    @(negedge Clock);
    Reset = 1'b0;
    BitEn = 1'b0;
    LineIn = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge Clock);
      #1;
      check_reset_outputs(tag);
    end
    @(negedge Clock);
    Reset = 1'b1;
    line_lvl = 1'b1;
    e_data = 8'h00;
    e_len  = 8'h00;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[23];
    int   lines[23] = '{1,0,1,0,1,0,1,1,  0,0,1,1,1,0,0,1,  1,1,1,1,1,1,1};

    // Sync (0x7E), data 0xA5, then seven held samples ending the frame.
    for (int i = 0; i < 23; i++) begin
      tbl[i].line   = lines[i][0];
      tbl[i].gap    = i % 4;
      tbl[i].e.p    = P_NONE;
      tbl[i].e.busy = (i >= 7 && i < 22);
      tbl[i].e.data = (i >= 15) ? 8'hA5 : 8'h00;
      tbl[i].e.len  = (i >= 15) ? 8'd1 : 8'd0;
    end
    tbl[7].e.p  = P_FS;
    tbl[15].e.p = P_DV;
    tbl[22].e.p = P_FD;

    do_reset(2, "reset");

    for (int i = 0; i < 23; i++)
      drive(tbl[i].line, tbl[i].gap, tbl[i].e, $sformatf("main[%0d]", i));
    line_lvl = 1'b1;
    e_data = 8'hA5;
    e_len  = 8'd1;

    // Stuffing: six zeros, stuffed one, two zeros -> 0x00; zero-run carries on.
    send_byte(8'h7E, 8, P_FS, 1'b0, 1'b1, 8'hA5, 8'd0, "stuff_sync");
    send_zeros(6, P_NONE, 1'b1, "stuff_z6");
    send_dec(1'b1, P_NONE, 1'b1, "stuff_bit");
    send_dec(1'b0, P_NONE, 1'b1, "stuff_b6");
    e_data = 8'h00;
    e_len  = 8'd1;
    send_dec(1'b0, P_DV, 1'b1, "stuff_byte");
    send_zeros(5, P_FD, 1'b0, "stuff_eof");

    // Bad end of frame: seven data bits pending when the marker arrives.
    send_byte(8'h7E, 8, P_FS, 1'b0, 1'b1, 8'h00, 8'd0, "bad_sync");
    send_dec(1'b1, P_NONE, 1'b1, "bad_one");
    send_zeros(7, P_FE, 1'b0, "bad_eof");

    // Length overflow on the MAX_LEN=2 instance.
    sel2 = 1'b1;
    send_byte(8'h7E, 8, P_FS, 1'b0, 1'b1, 8'h00, 8'd0, "ovf_sync");
    send_byte(8'h11, 8, P_DV, 1'b1, 1'b1, 8'h11, 8'd1, "ovf_b0");
    send_byte(8'h22, 8, P_DV, 1'b1, 1'b1, 8'h22, 8'd2, "ovf_b1");
    send_byte(8'h33, 8, P_FE, 1'b1, 1'b0, 8'h22, 8'd2, "ovf_b2");
    sel2 = 1'b0;

    // Reset mid-frame, then a clean frame must still decode.
    do_reset(1, "pre_reset");
    send_byte(8'h7E, 8, P_FS, 1'b0, 1'b1, 8'h00, 8'd0, "mid_sync");
    send_byte(8'h5A, 8, P_DV, 1'b1, 1'b1, 8'h5A, 8'd1, "mid_byte");
    send_byte(8'h0F, 4, P_NONE, 1'b1, 1'b1, 8'h5A, 8'd1, "mid_part");
    do_reset(1, "mid_reset");
    send_byte(8'h7E, 8, P_FS, 1'b0, 1'b1, 8'h00, 8'd0, "post_sync");
    send_byte(8'h3C, 8, P_DV, 1'b1, 1'b1, 8'h3C, 8'd1, "post_byte");
    send_zeros(5, P_FD, 1'b0, "post_eof");

    @(negedge Clock);
    BitEn = 1'b0;
    cmp("scoreboard_drained", 8'(q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
